issue_picker: RTL and testbench
===============================

# issue_picker

Select logic for the 4-entry issue window. Each cycle it picks at most one ready window entry, oldest first, subject to functional-unit availability and load/store ordering. The one-hot pick drives the queue's `wed`. The picked entry's destination ROB tag goes into a per-pipe issue register (ALU, MUL, MEM, BRU) with a valid/ready handshake toward the execute stage. It sits between the issue queue and the execute pipes, and owns MUL occupancy tracking and branch-flush squashing of issue slots.

## Interface
- `MUL_LAT`, default 4: MUL unit occupancy in cycles per accepted operation (≥1, non-pipelined unit).
- `clk`  in  1  clock.
- `resetn`  in  1  reset, synchronous, active-low.
- `bco_valid`  in  1  branch commit override / flush.
- `win_valid`  in  4  window entry valid, bit 0 = oldest.
- `win_src0_rdy`, `win_src1_rdy`  in  4 each  operand ready per entry.
- `win_pipe_alu`, `win_pipe_mul`, `win_pipe_mem`, `win_pipe_bru`  in  4 each  target pipe per entry; one-hot across pipes per entry.
- `win_dst_rob`  in  16  4-bit destination ROB tag per entry, entry j at [4j+:4].
- `pick`  out  4  one-hot or zero issue pick, to the queue's `wed`; combinational.
- `iss_alu_valid`, `iss_mul_valid`, `iss_mem_valid`, `iss_bru_valid`  out  1 each  issue register valid.
- `iss_alu_rob`, `iss_mul_rob`, `iss_mem_rob`, `iss_bru_rob`  out  4 each  issued destination ROB tag.
- `iss_alu_ready`, `iss_mul_ready`, `iss_mem_ready`, `iss_bru_ready`  in  1 each  execute pipe accepts.
- `mul_busy`  out  1  MUL occupancy counter nonzero.

## Operation
- Slot free for pipe P: `~iss_P_valid | iss_P_ready`.
- MUL additionally requires `mul_cnt == 0`.
- Entry j is eligible when all of the following hold:
  - `win_valid[j]`, `win_src0_rdy[j]` and `win_src1_rdy[j]` are set.
  - Its target pipe slot is free.
  - If `win_pipe_mem[j]`: no valid entry k<j has `win_pipe_mem[k]`. Memory ops issue strictly in window order.
- An entry with no pipe bit set is never eligible. Eligibility does not depend on ALU/BRU ordering.
- `pick` selects the lowest-index eligible entry. `pick` = 0 if none is eligible or `bco_valid` = 1.
- Only one pick per cycle; the queue compaction supports a single removal.
- Issue register P on clk:
  - `bco_valid`: valid ← 0.
  - Else if pick targets P: valid ← 1, rob ← `win_dst_rob` of the picked entry.
  - Else if `iss_P_ready`: valid ← 0.
  - Else hold.
- MUL counter `mul_cnt`, width clog2(MUL_LAT+1):
  - Loads MUL_LAT−1 when `iss_mul_valid & iss_mul_ready`.
  - Otherwise decrements while nonzero.
  - `bco_valid` does not affect it: the unit stays occupied by the squashed op.
- Reset: every `iss_*_valid` = 0, every `iss_*_rob` = 0, `mul_cnt` = 0, `mul_busy` = 0. `pick` = 0 while `resetn` = 0.

## Timing
- Pick is combinational from window state in the same cycle. The queue shifts on the same edge that loads the issue register.
- Pick-to-`iss_P_valid`: 1 cycle.
- Back-to-back issue to the same pipe every cycle when its ready is held high. Zero bubble: the slot counts as free while the old op is being accepted.
- MUL: after a handshake at cycle t, the next MUL pick can occur at cycle t+MUL_LAT at the earliest. With MUL_LAT=1 there is no stall.
- Flush: `pick` is forced to 0 in the `bco_valid` cycle, and all issue valids are 0 the following cycle.
- A ready op held in the issue register while a flush arrives is dropped, not delivered.
- Reset asserted mid-operation clears everything next edge, regardless of handshake state.

## Structure
- Shared package (`issue_pkg`) holds: `WIN_DEPTH`=4, `ROB_W`=4, pipe index constants (ALU=0, MUL=1, MEM=2, BRU=3).
- One sub-module `issue_slot`: a valid/rob register with the ready/flush rules above, instantiated 4×.
- The picker (priority encode + mem ordering mask) and the MUL counter live at top level.

## Test plan
- All 4 entries valid and ready, each targeting ALU, all readies = 1 → pick 0001 for 4 consecutive cycles as the window shifts; `iss_alu_valid` high from cycle 1. Tags appear in order 0..3.
- Entry0 MEM with src1 not ready, entry1 MEM ready, entry2 ALU ready → pick = 0100. Entry1 is blocked by ordering.
- MUL_LAT=4, two ready MUL ops, `iss_mul_ready`=1 → handshake at t, `mul_busy` high t+1..t+3, second pick at t+4.
- `iss_bru_ready`=0 with BRU valid, window entry0 BRU ready, entry1 ALU ready → pick = 0010; BRU register holds its tag.
- `bco_valid` pulse with all four issue valids high and ALU-ready entries in the window → pick = 0 that cycle, all valids 0 next cycle, `mul_cnt` unchanged.
- Drop `resetn` mid-MUL occupancy (`mul_cnt`=2) → next cycle `mul_cnt`=0 and all outputs 0.

Source files
------------

// File: rtl/issue_pkg.sv
// Shared constants for the issue stage.
//   WIN_DEPTH : number of issue window entries (entry 0 is the oldest)
//   ROB_W     : width of a destination ROB tag
//   PIPE_*    : index of each execute pipe in per-pipe vectors
package issue_pkg;

  localparam int WIN_DEPTH = 4;
  localparam int ROB_W     = 4;
  localparam int NUM_PIPES = 4;

  localparam int PIPE_ALU  = 0;
  localparam int PIPE_MUL  = 1;
  localparam int PIPE_MEM  = 2;
  localparam int PIPE_BRU  = 3;

endpackage

// File: rtl/issue_slot.sv
// One per-pipe issue register: holds the ROB tag of the op waiting for its
// execute pipe, with a valid/ready handshake and a flush that drops it.
//   clk, resetn   : clock, synchronous active-low reset
//   flush         : branch flush, drops the held op
//   load, load_rob: a new op was picked for this pipe this cycle
//   ready         : execute pipe accepts the held op
//   valid, rob    : registered issue valid and destination ROB tag
module issue_slot
  import issue_pkg::*;
(
  input  logic             clk,
  input  logic             resetn,
  input  logic             flush,
  input  logic             load,
  input  logic [ROB_W-1:0] load_rob,
  input  logic             ready,
  output logic             valid,
  output logic [ROB_W-1:0] rob
);

  // Issue register update: flush beats a new load, a new load beats a retire.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      valid <= 1'b0;
      rob   <= {ROB_W{1'b0}};
    end else if (flush) begin
      valid <= 1'b0;
      rob   <= rob;
    end else if (load) begin
      valid <= 1'b1;
      rob   <= load_rob;
    end else if (ready) begin
      valid <= 1'b0;
      rob   <= rob;
    end else begin
      valid <= valid;
      rob   <= rob;
    end
  end

endmodule

// File: rtl/issue_picker.sv
// Issue select for the 4-entry window: picks the oldest ready entry whose
// target pipe can take it, keeps memory ops in window order, tracks MUL
// occupancy and loads the per-pipe issue registers.
//   clk, resetn          : clock, synchronous active-low reset
//   bco_valid            : branch flush; suppresses the pick, empties issue regs
//   win_*                : window entry state, bit 0 = oldest
//   pick                 : one-hot (or zero) entry removed this cycle
//   iss_P_valid/rob/ready: per-pipe issue handshake toward execute
//   mul_busy             : MUL unit still occupied by an accepted op
module issue_picker
  import issue_pkg::*;
#(
  parameter int MUL_LAT = 4
) (
  input  logic                       clk,
  input  logic                       resetn,
  input  logic                       bco_valid,
  input  logic [WIN_DEPTH-1:0]       win_valid,
  input  logic [WIN_DEPTH-1:0]       win_src0_rdy,
  input  logic [WIN_DEPTH-1:0]       win_src1_rdy,
  input  logic [WIN_DEPTH-1:0]       win_pipe_alu,
  input  logic [WIN_DEPTH-1:0]       win_pipe_mul,
  input  logic [WIN_DEPTH-1:0]       win_pipe_mem,
  input  logic [WIN_DEPTH-1:0]       win_pipe_bru,
  input  logic [WIN_DEPTH*ROB_W-1:0] win_dst_rob,
  output logic [WIN_DEPTH-1:0]       pick,
  output logic                       iss_alu_valid,
  output logic                       iss_mul_valid,
  output logic                       iss_mem_valid,
  output logic                       iss_bru_valid,
  output logic [ROB_W-1:0]           iss_alu_rob,
  output logic [ROB_W-1:0]           iss_mul_rob,
  output logic [ROB_W-1:0]           iss_mem_rob,
  output logic [ROB_W-1:0]           iss_bru_rob,
  input  logic                       iss_alu_ready,
  input  logic                       iss_mul_ready,
  input  logic                       iss_mem_ready,
  input  logic                       iss_bru_ready,
  output logic                       mul_busy
);

  localparam int CNT_W = $clog2(MUL_LAT + 1);

  logic [CNT_W-1:0]     mul_cnt_r;
  logic                 mul_hs_s;
  logic [NUM_PIPES-1:0] slot_free_s;
  logic [WIN_DEPTH-1:0] elig_s;
  logic [WIN_DEPTH-1:0] pick_s;
  logic [ROB_W-1:0]     pick_rob_s;
  logic [NUM_PIPES-1:0] load_s;

  assign mul_hs_s = iss_mul_valid & iss_mul_ready;

  // Per-pipe slot availability. An op being accepted frees its slot in the
  // same cycle. For MUL with MUL_LAT>1 that accepted op starts occupying the
  // unit right now, so the slot is not offered during the handshake cycle;
  // this makes the earliest following MUL pick land MUL_LAT cycles later.
  always_comb begin
    slot_free_s           = {NUM_PIPES{1'b0}};
    slot_free_s[PIPE_ALU] = ~iss_alu_valid | iss_alu_ready;
    slot_free_s[PIPE_MEM] = ~iss_mem_valid | iss_mem_ready;
    slot_free_s[PIPE_BRU] = ~iss_bru_valid | iss_bru_ready;
    if (MUL_LAT == 1) begin
      slot_free_s[PIPE_MUL] = (~iss_mul_valid | iss_mul_ready) & (mul_cnt_r == {CNT_W{1'b0}});
    end else begin
      slot_free_s[PIPE_MUL] = ~iss_mul_valid & (mul_cnt_r == {CNT_W{1'b0}});
    end
  end

  // Eligibility: operands ready, target slot free, and a memory op only when
  // no older valid memory op sits ahead of it (valid-ness alone blocks, not
  // readiness, so memory ops leave the window strictly in order).
  always_comb begin
    logic mem_seen;
    logic tgt_free;
    elig_s   = {WIN_DEPTH{1'b0}};
    mem_seen = 1'b0;
    for (int j = 0; j < WIN_DEPTH; j++) begin
      tgt_free = (win_pipe_alu[j] & slot_free_s[PIPE_ALU]) |
                 (win_pipe_mul[j] & slot_free_s[PIPE_MUL]) |
                 (win_pipe_mem[j] & slot_free_s[PIPE_MEM]) |
                 (win_pipe_bru[j] & slot_free_s[PIPE_BRU]);
      elig_s[j] = win_valid[j] & win_src0_rdy[j] & win_src1_rdy[j] & tgt_free &
                  ~(win_pipe_mem[j] & mem_seen);
      mem_seen  = mem_seen | (win_valid[j] & win_pipe_mem[j]);
    end
  end

  // Oldest-first priority encode; nothing is picked in reset or on a flush.
  always_comb begin
    logic found;
    pick_s = {WIN_DEPTH{1'b0}};
    found  = 1'b0;
    for (int j = 0; j < WIN_DEPTH; j++) begin
      if (elig_s[j] && !found) begin
        pick_s[j] = 1'b1;
        found     = 1'b1;
      end else begin
        pick_s[j] = 1'b0;
      end
    end
    if (!resetn || bco_valid) begin
      pick_s = {WIN_DEPTH{1'b0}};
    end else begin
      pick_s = pick_s;
    end
  end

  assign pick = pick_s;

  // Tag of the picked entry and which pipe it is headed for.
  always_comb begin
    pick_rob_s = {ROB_W{1'b0}};
    for (int j = 0; j < WIN_DEPTH; j++) begin
      if (pick_s[j]) begin
        pick_rob_s = win_dst_rob[ROB_W*j +: ROB_W];
      end else begin
        pick_rob_s = pick_rob_s;
      end
    end
    load_s           = {NUM_PIPES{1'b0}};
    load_s[PIPE_ALU] = |(pick_s & win_pipe_alu);
    load_s[PIPE_MUL] = |(pick_s & win_pipe_mul);
    load_s[PIPE_MEM] = |(pick_s & win_pipe_mem);
    load_s[PIPE_BRU] = |(pick_s & win_pipe_bru);
  end

  // MUL occupancy: reloads on every accepted op; a flush does not release it
  // because the squashed op is still in the non-pipelined unit.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      mul_cnt_r <= {CNT_W{1'b0}};
    end else if (mul_hs_s) begin
      mul_cnt_r <= CNT_W'(MUL_LAT - 1);
    end else if (mul_cnt_r != {CNT_W{1'b0}}) begin
      mul_cnt_r <= mul_cnt_r - CNT_W'(1);
    end else begin
      mul_cnt_r <= mul_cnt_r;
    end
  end

  assign mul_busy = (mul_cnt_r != {CNT_W{1'b0}});

  issue_slot u_slot_alu (
    .clk(clk), .resetn(resetn), .flush(bco_valid),
    .load(load_s[PIPE_ALU]), .load_rob(pick_rob_s), .ready(iss_alu_ready),
    .valid(iss_alu_valid), .rob(iss_alu_rob)
  );

  issue_slot u_slot_mul (
    .clk(clk), .resetn(resetn), .flush(bco_valid),
    .load(load_s[PIPE_MUL]), .load_rob(pick_rob_s), .ready(iss_mul_ready),
    .valid(iss_mul_valid), .rob(iss_mul_rob)
  );

  issue_slot u_slot_mem (
    .clk(clk), .resetn(resetn), .flush(bco_valid),
    .load(load_s[PIPE_MEM]), .load_rob(pick_rob_s), .ready(iss_mem_ready),
    .valid(iss_mem_valid), .rob(iss_mem_rob)
  );

  issue_slot u_slot_bru (
    .clk(clk), .resetn(resetn), .flush(bco_valid),
    .load(load_s[PIPE_BRU]), .load_rob(pick_rob_s), .ready(iss_bru_ready),
    .valid(iss_bru_valid), .rob(iss_bru_rob)
  );

endmodule

// File: tb/tb_issue_picker.sv
// Self-checking bench for issue_picker: a table of single-cycle pick
// vectors plus hand-written multi-cycle sequences. Expected issue-register
// contents are queued when a pick is driven and compared after the edge.
module tb_issue_picker;

  localparam int MUL_LAT = 4;

  logic        clk = 1'b0;
  logic        resetn;
  logic        bco_valid;
  logic [3:0]  win_valid, win_src0_rdy, win_src1_rdy;
  logic [3:0]  win_pipe_alu, win_pipe_mul, win_pipe_mem, win_pipe_bru;
  logic [15:0] win_dst_rob;
  logic [3:0]  pick;
  logic        iss_alu_valid, iss_mul_valid, iss_mem_valid, iss_bru_valid;
  logic [3:0]  iss_alu_rob, iss_mul_rob, iss_mem_rob, iss_bru_rob;
  logic        iss_alu_ready, iss_mul_ready, iss_mem_ready, iss_bru_ready;
  logic        mul_busy;

  issue_picker #(.MUL_LAT(MUL_LAT)) dut (
    .clk(clk), .resetn(resetn), .bco_valid(bco_valid),
    .win_valid(win_valid), .win_src0_rdy(win_src0_rdy), .win_src1_rdy(win_src1_rdy),
    .win_pipe_alu(win_pipe_alu), .win_pipe_mul(win_pipe_mul),
    .win_pipe_mem(win_pipe_mem), .win_pipe_bru(win_pipe_bru),
    .win_dst_rob(win_dst_rob), .pick(pick),
    .iss_alu_valid(iss_alu_valid), .iss_mul_valid(iss_mul_valid),
    .iss_mem_valid(iss_mem_valid), .iss_bru_valid(iss_bru_valid),
    .iss_alu_rob(iss_alu_rob), .iss_mul_rob(iss_mul_rob),
    .iss_mem_rob(iss_mem_rob), .iss_bru_rob(iss_bru_rob),
    .iss_alu_ready(iss_alu_ready), .iss_mul_ready(iss_mul_ready),
    .iss_mem_ready(iss_mem_ready), .iss_bru_ready(iss_bru_ready),
    .mul_busy(mul_busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int         pipe;
    logic [3:0] rob;
  } exp_t;
  exp_t sb[$];

  typedef struct {
    logic [3:0]  v, s0, s1, alu, mul, mem, bru;
    logic [15:0] rob;
    logic        bco;
    logic [3:0]  exp_pick;
    int          exp_pipe;
    logic [3:0]  exp_rob;
  } vec_t;
  vec_t vecs[10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_win();
    win_valid = 4'h0; win_src0_rdy = 4'h0; win_src1_rdy = 4'h0;
    win_pipe_alu = 4'h0; win_pipe_mul = 4'h0; win_pipe_mem = 4'h0; win_pipe_bru = 4'h0;
    win_dst_rob = 16'h0000;
  endtask

  task automatic set_entry(input int j, input int p, input logic [3:0] rob, input logic rdy);
    win_valid[j]    = 1'b1;
    win_src0_rdy[j] = rdy;
    win_src1_rdy[j] = 1'b1;
    win_pipe_alu[j] = (p == 0);
    win_pipe_mul[j] = (p == 1);
    win_pipe_mem[j] = (p == 2);
    win_pipe_bru[j] = (p == 3);
    win_dst_rob[4*j +: 4] = rob;
  endtask

  task automatic do_reset();
    resetn = 1'b0; bco_valid = 1'b0;
    clear_win();
    iss_alu_ready = 1'b1; iss_mul_ready = 1'b1; iss_mem_ready = 1'b1; iss_bru_ready = 1'b1;
    tick();
    resetn = 1'b1;
    sb.delete();
  endtask

  function automatic logic [3:0] rob_of(input int p);
    case (p)
      0: return iss_alu_rob;
      1: return iss_mul_rob;
      2: return iss_mem_rob;
      3: return iss_bru_rob;
      default: return 4'h0;
    endcase
  endfunction

  // Drain the scoreboard: every queued pipe must be valid with its tag,
  // every other pipe must be empty.
  task automatic check_sb(input string name);
    logic [3:0] vmask;
    exp_t e;
    vmask = 4'h0;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      vmask[e.pipe] = 1'b1;
      chk({name, "_rob"}, {28'h0, rob_of(e.pipe)}, {28'h0, e.rob});
    end
    chk({name, "_valids"}, {28'h0, iss_bru_valid, iss_mem_valid, iss_mul_valid, iss_alu_valid},
        {28'h0, vmask});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] q[$];

    // v, s0, s1, alu, mul, mem, bru, rob, bco, exp_pick, exp_pipe, exp_rob
    vecs[0] = '{4'hF, 4'hF, 4'hF, 4'hF, 4'h0, 4'h0, 4'h0, 16'h4321, 1'b0, 4'b0001,  0, 4'h1};
    vecs[1] = '{4'h7, 4'h7, 4'h6, 4'h4, 4'h0, 4'h3, 4'h0, 16'h0CBA, 1'b0, 4'b0100,  0, 4'hC};
    vecs[2] = '{4'h0, 4'hF, 4'hF, 4'hF, 4'h0, 4'h0, 4'h0, 16'h1111, 1'b0, 4'b0000, -1, 4'h0};
    vecs[3] = '{4'h3, 4'h3, 4'h3, 4'h0, 4'h0, 4'h0, 4'h2, 16'h0070, 1'b0, 4'b0010,  3, 4'h7};
    vecs[4] = '{4'h3, 4'h2, 4'h3, 4'h1, 4'h2, 4'h0, 4'h0, 16'h0050, 1'b0, 4'b0010,  1, 4'h5};
    vecs[5] = '{4'h2, 4'h3, 4'h3, 4'h0, 4'h0, 4'h3, 4'h0, 16'h00E0, 1'b0, 4'b0010,  2, 4'hE};
    vecs[6] = '{4'h8, 4'hF, 4'hF, 4'h8, 4'h0, 4'h0, 4'h0, 16'h9000, 1'b0, 4'b1000,  0, 4'h9};
    vecs[7] = '{4'hF, 4'hF, 4'hF, 4'hF, 4'h0, 4'h0, 4'h0, 16'h4321, 1'b1, 4'b0000, -1, 4'h0};
    vecs[8] = '{4'hF, 4'hE, 4'hF, 4'h0, 4'h0, 4'hF, 4'h0, 16'h4321, 1'b0, 4'b0000, -1, 4'h0};
    vecs[9] = '{4'h3, 4'h3, 4'h3, 4'h2, 4'h0, 4'h1, 4'h0, 16'h0021, 1'b0, 4'b0001,  2, 4'h1};

    do_reset();
    chk("reset_valids", {28'h0, iss_bru_valid, iss_mem_valid, iss_mul_valid, iss_alu_valid}, 32'h0);
    chk("reset_robs", {16'h0, iss_alu_rob, iss_mul_rob, iss_mem_rob, iss_bru_rob}, 32'h0);
    chk("reset_busy", {31'h0, mul_busy}, 32'h0);

    // Table of single-pick vectors, each from an empty issue stage.
    for (int i = 0; i < 10; i++) begin
      do_reset();
      win_valid = vecs[i].v; win_src0_rdy = vecs[i].s0; win_src1_rdy = vecs[i].s1;
      win_pipe_alu = vecs[i].alu; win_pipe_mul = vecs[i].mul;
      win_pipe_mem = vecs[i].mem; win_pipe_bru = vecs[i].bru;
      win_dst_rob = vecs[i].rob; bco_valid = vecs[i].bco;
      #1;
      chk($sformatf("vec%0d_pick", i), {28'h0, pick}, {28'h0, vecs[i].exp_pick});
      if (vecs[i].exp_pipe >= 0) sb.push_back('{vecs[i].exp_pipe, vecs[i].exp_rob});
      tick();
      bco_valid = 1'b0;
      check_sb($sformatf("vec%0d", i));
    end

    // ALU stream: window shifts each cycle, zero-bubble issue in order.
    do_reset();
    q = '{4'hA, 4'hB, 4'hC, 4'hD};
    for (int c = 0; c < 4; c++) begin
      clear_win();
      for (int k = 0; k < q.size(); k++) set_entry(k, 0, q[k], 1'b1);
      #1;
      chk($sformatf("alu_stream%0d_pick", c), {28'h0, pick}, 32'h1);
      sb.push_back('{0, q[0]});
      tick();
      void'(q.pop_front());
      check_sb($sformatf("alu_stream%0d", c));
    end
    clear_win();
    tick();
    check_sb("alu_stream_drain");

    // MUL occupancy, with a flush while the unit is busy.
    do_reset();
    set_entry(0, 1, 4'h1, 1'b1);
    set_entry(1, 1, 4'h2, 1'b1);
    #1;
    chk("mul_pick0", {28'h0, pick}, 32'h1);
    sb.push_back('{1, 4'h1});
    tick();
    check_sb("mul_first");
    clear_win();
    set_entry(0, 1, 4'h2, 1'b1);
    #1;
    chk("mul_hs_cycle_pick", {28'h0, pick}, 32'h0);
    tick();
    for (int c = 0; c < MUL_LAT - 1; c++) begin
      chk($sformatf("mul_busy_c%0d", c), {31'h0, mul_busy}, 32'h1);
      chk($sformatf("mul_stall_c%0d", c), {28'h0, pick}, 32'h0);
      bco_valid = (c == 1);
      tick();
      bco_valid = 1'b0;
    end
    chk("mul_busy_done", {31'h0, mul_busy}, 32'h0);
    chk("mul_pick1", {28'h0, pick}, 32'h1);
    sb.push_back('{1, 4'h2});
    tick();
    check_sb("mul_second");

    // BRU held by backpressure while a younger ALU op issues.
    do_reset();
    iss_bru_ready = 1'b0;
    set_entry(0, 3, 4'h9, 1'b1);
    #1;
    chk("bru_pick0", {28'h0, pick}, 32'h1);
    sb.push_back('{3, 4'h9});
    tick();
    check_sb("bru_first");
    clear_win();
    set_entry(0, 3, 4'h3, 1'b1);
    set_entry(1, 0, 4'h4, 1'b1);
    #1;
    chk("bru_blocked_pick", {28'h0, pick}, 32'h2);
    sb.push_back('{3, 4'h9});
    sb.push_back('{0, 4'h4});
    tick();
    check_sb("bru_hold");

    // Flush with all four issue registers full.
    do_reset();
    iss_alu_ready = 1'b0; iss_mul_ready = 1'b0; iss_mem_ready = 1'b0; iss_bru_ready = 1'b0;
    for (int p = 0; p < 4; p++) begin
      clear_win();
      set_entry(0, p, 4'(p + 1), 1'b1);
      #1;
      chk($sformatf("fill%0d_pick", p), {28'h0, pick}, 32'h1);
      sb.push_back('{p, 4'(p + 1)});
      tick();
    end
    check_sb("fill_all");
    clear_win();
    set_entry(0, 0, 4'h5, 1'b1);
    set_entry(1, 0, 4'h6, 1'b1);
    iss_alu_ready = 1'b1;
    bco_valid = 1'b1;
    #1;
    chk("flush_pick", {28'h0, pick}, 32'h0);
    tick();
    bco_valid = 1'b0;
    clear_win();
    check_sb("flush_after");
    chk("flush_busy", {31'h0, mul_busy}, 32'h0);

    // Reset in the middle of MUL occupancy.
    do_reset();
    iss_alu_ready = 1'b0;
    set_entry(0, 1, 4'h6, 1'b1);
    tick();
    clear_win();
    tick();
    set_entry(0, 0, 4'h7, 1'b1);
    tick();
    clear_win();
    chk("rst_mid_busy_before", {31'h0, mul_busy}, 32'h1);
    chk("rst_mid_alu_before", {31'h0, iss_alu_valid}, 32'h1);
    resetn = 1'b0;
    set_entry(0, 3, 4'h8, 1'b1);
    #1;
    chk("rst_mid_pick", {28'h0, pick}, 32'h0);
    tick();
    resetn = 1'b1;
    clear_win();
    chk("rst_mid_busy", {31'h0, mul_busy}, 32'h0);
    chk("rst_mid_valids", {28'h0, iss_bru_valid, iss_mem_valid, iss_mul_valid, iss_alu_valid}, 32'h0);
    chk("rst_mid_robs", {16'h0, iss_alu_rob, iss_mul_rob, iss_mem_rob, iss_bru_rob}, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
